// File: rtl/regfile.sv
// regfile: two-read/one-write register file with x0 hardwired to zero and same-cycle write bypass
module regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] reg_waddr,
   input  logic [DATA_W-1:0] reg_wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] reg_addr1,
   output logic [DATA_W-1:0] reg_data1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] reg_addr2,
   output logic [DATA_W-1:0] reg_data2
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [DATA_W-1:0] mem_d [NUM_REGS];

   // next array contents: a write to any index but x0 lands on the next edge
   always_comb begin
      mem_d = mem_q;
      if (we && reg_waddr != '0) mem_d[reg_waddr] = reg_wdata;
   end

   // storage; reset clears every entry and discards any write pending on that edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q <= '{default: '0};
      else        mem_q <= mem_d;
   end

   // read ports: reset, disable and x0 force zero; a matching write is forwarded before the array
   always_comb begin
      reg_data1 = (!rst_n || !re1 || reg_addr1 == '0) ? '0 :
                  (we && reg_waddr == reg_addr1)      ? reg_wdata : mem_q[reg_addr1];
      reg_data2 = (!rst_n || !re2 || reg_addr2 == '0) ? '0 :
                  (we && reg_waddr == reg_addr2)      ? reg_wdata : mem_q[reg_addr2];
   end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomized checks of regfile against an array reference model
module tb_regfile;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] reg_waddr = '0;
   logic [DW-1:0] reg_wdata = '0;
   logic          re1 = 1'b0;
   logic [AW-1:0] reg_addr1 = '0;
   logic          re2 = 1'b0;
   logic [AW-1:0] reg_addr2 = '0;
   logic [DW-1:0] reg_data1;
   logic [DW-1:0] reg_data2;

   logic [DW-1:0] ref_mem [NR];
   int vectors = 0;
   int miscompares = 0;

   regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .re1(re1), .reg_addr1(reg_addr1), .reg_data1(reg_data1),
      .re2(re2), .reg_addr2(reg_addr2), .reg_data2(reg_data2)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // expected read value straight from the read priority rules
   function automatic logic [DW-1:0] model_read(logic en, logic [AW-1:0] a);
      if (!rst_n || !en || a == 0) return '0;
      if (we && reg_waddr == a) return reg_wdata;
      return ref_mem[a];
   endfunction

   // advance to the next rising edge, commit the write to the model, settle 1 unit after
   task automatic tick();
      @(posedge clk);
      if (rst_n && we && reg_waddr != 0) ref_mem[reg_waddr] = reg_wdata;
      #1;
   endtask

   task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic r1, input logic [AW-1:0] a1, input logic r2, input logic [AW-1:0] a2);
      we = w; reg_waddr = wa; reg_wdata = wd;
      re1 = r1; reg_addr1 = a1; re2 = r2; reg_addr2 = a2;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < NR; i++) ref_mem[i] = '0;
      rst_n = 1'b0;
      drive(1'b1, 5'd5, 32'hCAFE_F00D, 1'b1, 5'd5, 1'b1, 5'd31);
      tick();
      vectors++;
      if (reg_data1 !== 32'h0) begin
         miscompares++; $display("FAIL reset_port1: got %h expected %h", reg_data1, 32'h0);
      end
      vectors++;
      if (reg_data2 !== 32'h0) begin
         miscompares++; $display("FAIL reset_port2: got %h expected %h", reg_data2, 32'h0);
      end
      rst_n = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
      vectors++;
      if (reg_data1 !== 32'h0) begin
         miscompares++; $display("FAIL reset_x5_after: got %h expected %h", reg_data1, 32'h0);
      end
      tick();
   endtask

   task automatic test_write_read();
      drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
      vectors++;
      if (reg_data1 !== 32'hDEAD_BEEF) begin
         miscompares++; $display("FAIL write_read_x3: got %h expected %h", reg_data1, 32'hDEAD_BEEF);
      end
      vectors++;
      if (reg_data2 !== 32'h0) begin
         miscompares++; $display("FAIL write_read_x4: got %h expected %h", reg_data2, 32'h0);
      end
      tick();
   endtask

   task automatic test_bypass();
      drive(1'b1, 5'd7, 32'h0000_0055, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      drive(1'b1, 5'd7, 32'h0000_1234, 1'b1, 5'd7, 1'b1, 5'd7);
      vectors++;
      if (reg_data1 !== 32'h0000_1234) begin
         miscompares++; $display("FAIL bypass_port1: got %h expected %h", reg_data1, 32'h0000_1234);
      end
      vectors++;
      if (reg_data2 !== 32'h0000_1234) begin
         miscompares++; $display("FAIL bypass_port2: got %h expected %h", reg_data2, 32'h0000_1234);
      end
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7);
      vectors++;
      if (reg_data1 !== 32'h0000_1234) begin
         miscompares++; $display("FAIL bypass_stored: got %h expected %h", reg_data1, 32'h0000_1234);
      end
      tick();
   endtask

   task automatic test_x0();
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
      vectors++;
      if (reg_data1 !== 32'h0) begin
         miscompares++; $display("FAIL x0_same_cycle: got %h expected %h", reg_data1, 32'h0);
      end
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
      vectors++;
      if (reg_data1 !== 32'h0) begin
         miscompares++; $display("FAIL x0_next_cycle: got %h expected %h", reg_data1, 32'h0);
      end
      tick();
   endtask

   task automatic test_re_gating();
      drive(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b0, 5'd9);
      vectors++;
      if (reg_data2 !== 32'h0) begin
         miscompares++; $display("FAIL re2_low: got %h expected %h", reg_data2, 32'h0);
      end
      drive(1'b1, 5'd9, 32'h1111_2222, 1'b0, 5'd9, 1'b0, 5'd9);
      vectors++;
      if (reg_data1 !== 32'h0) begin
         miscompares++; $display("FAIL re1_low_bypass: got %h expected %h", reg_data1, 32'h0);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd9);
      vectors++;
      if (reg_data2 !== 32'hA5A5_A5A5) begin
         miscompares++; $display("FAIL re2_high: got %h expected %h", reg_data2, 32'hA5A5_A5A5);
      end
      tick();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 5'd12, 32'h0000_0077, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd12);
      vectors++;
      if (reg_data1 !== 32'h0000_0077) begin
         miscompares++; $display("FAIL async_pre: got %h expected %h", reg_data1, 32'h0000_0077);
      end
      #1 rst_n = 1'b0;
      for (int i = 0; i < NR; i++) ref_mem[i] = '0;
      #1;
      vectors++;
      if (reg_data1 !== 32'h0) begin
         miscompares++; $display("FAIL async_drop_port1: got %h expected %h", reg_data1, 32'h0);
      end
      vectors++;
      if (reg_data2 !== 32'h0) begin
         miscompares++; $display("FAIL async_drop_port2: got %h expected %h", reg_data2, 32'h0);
      end
      drive(1'b1, 5'd12, 32'h0000_0099, 1'b1, 5'd12, 1'b1, 5'd12);
      tick();
      #2 we = 1'b0; rst_n = 1'b1;
      #1;
      vectors++;
      if (reg_data1 !== 32'h0) begin
         miscompares++; $display("FAIL async_release_x12: got %h expected %h", reg_data1, 32'h0);
      end
      tick();
   endtask

   task automatic test_random();
      logic [DW-1:0] e1, e2;
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1) == 1,
               AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7)),
               $urandom(),
               $urandom_range(0, 7) != 0,
               AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7)),
               $urandom_range(0, 7) != 0,
               AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7)));
         e1 = model_read(re1, reg_addr1);
         e2 = model_read(re2, reg_addr2);
         vectors++;
         if (reg_data1 !== e1) begin
            miscompares++; $display("FAIL random_port1 x%0d: got %h expected %h", reg_addr1, reg_data1, e1);
         end
         vectors++;
         if (reg_data2 !== e2) begin
            miscompares++; $display("FAIL random_port2 x%0d: got %h expected %h", reg_addr2, reg_data2, e2);
         end
         tick();
      end
      for (int a = 0; a < NR; a++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b1, AW'(a), 1'b1, AW'(NR - 1 - a));
         vectors++;
         if (reg_data1 !== ref_mem[a]) begin
            miscompares++; $display("FAIL sweep_port1 x%0d: got %h expected %h", a, reg_data1, ref_mem[a]);
         end
         vectors++;
         if (reg_data2 !== ref_mem[NR - 1 - a]) begin
            miscompares++; $display("FAIL sweep_port2 x%0d: got %h expected %h", NR - 1 - a, reg_data2, ref_mem[NR - 1 - a]);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_x0();
      test_re_gating();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
